peri_initiator: RTL
===================

# peri_initiator

Bus initiator for the peripheral register interface: it accepts single load/store requests from the core's data-memory path and drives the peripheral strobe, address and data signals toward CSR-style responders. For guarded registers it automatically writes the unlock key into the responder's guard word immediately before the target write. It tracks one outstanding transaction at a time, matches it with the responder's data-valid pulse, and returns a response with an error flag when the responder does not answer within a timeout.

## Interface
- TIMEOUT_CYCLES, 255, maximum wait after a strobe for i_dout_32b_valid; legal range ≥1.
- GUARD_KEY, 16'h1234, key written to the guard word.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  request from core.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_guard  in  1  write needs an unlock first; ignored for reads.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  write data.
- o_req_ready  out  1  request accepted when i_req && o_req_ready.
- o_resp_valid  out  1  one-cycle response pulse; no backpressure.
- o_resp_rdata  out  32  read data; 0 for writes and errors.
- o_resp_err  out  1  timeout; qualified by o_resp_valid.
- o_addr_32b  out  32  peripheral address.
- o_wren  out  1  peripheral write strobe, one-cycle pulse.
- o_rden  out  1  peripheral read strobe, one-cycle pulse.
- o_din_32b  out  32  peripheral write data.
- i_dout_32b  in  32  peripheral read data.
- i_dout_32b_valid  in  1  peripheral completion; it is asserted the cycle after each strobe, for writes as well as reads.

## Operation
- States: IDLE, G_WAIT, WAIT. o_req_ready = (state == IDLE), driven combinationally from the state.
- On accept in IDLE:
  - Guarded write: register o_wren=1, o_addr_32b={i_req_addr[31:7],5'd1,2'b00}, o_din_32b={16'b0,GUARD_KEY}; latch the request; go to G_WAIT.
  - Otherwise: register o_wren=i_req_we, o_rden=!i_req_we, o_addr_32b={i_req_addr[31:2],2'b00}, o_din_32b=(we ? wdata : 0); go to WAIT.
- G_WAIT:
  - On i_dout_32b_valid, issue the latched target write next cycle and go to WAIT.
  - No other write is issued between the guard write and the target write, because the responder clears its guard on any write.
- WAIT:
  - On i_dout_32b_valid, register o_resp_valid=1, o_resp_err=0, o_resp_rdata=(read ? i_dout_32b : 0); go to IDLE.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1). Cleared at every strobe; increments each wait cycle without valid.
  - If valid is absent for TIMEOUT_CYCLES cycles in WAIT, pulse o_resp_valid with o_resp_err=1, rdata=0, then go to IDLE.
  - Timeout in G_WAIT skips the target write and gives the same error response.
- o_addr_32b and o_din_32b hold their values from a strobe until the next strobe. Strobes deassert after one cycle.
- i_dout_32b_valid in IDLE is ignored. A late valid that arrives after a timeout is dropped.
- Reset (asynchronous at any time, including mid-transaction): state=IDLE; o_wren, o_rden, o_resp_valid, o_resp_err = 0; o_addr_32b, o_din_32b, o_resp_rdata = 0; counter=0. No response is produced for an aborted transaction.

## Timing
- Accept edge = cycle 0.
- Plain read/write: strobe in cycle 1, responder valid in cycle 2, o_resp_valid in cycle 3. o_req_ready=1 in cycle 3, so a new request can be accepted in the response cycle.
- Guarded write: guard strobe in cycle 1, valid in cycle 2, target strobe in cycle 3, valid in cycle 4, response in cycle 5.
- Timeout: for a strobe in cycle S with no valid in cycles S+1..S+TIMEOUT_CYCLES, the error response appears in cycle S+TIMEOUT_CYCLES+1.
- Maximum throughput: one plain transaction per 3 cycles; one guarded transaction per 5 cycles.
- All outputs except o_req_ready are registered.

## Test plan
- Read of 0x0000000C, responder returns 0x20220601 -> o_rden cycle 1 with addr 0x0000000C; o_resp_valid cycle 3, rdata 0x20220601, err 0.
- Guarded write of 0x20240101 to 0x00000008 -> cycle 1: o_wren, addr 0x00000004, din 0x00001234. Cycle 3: o_wren, addr 0x00000008, din 0x20240101. Cycle 5: resp, err 0, rdata 0. Responder model's sw_version becomes 0x20240101.
- TIMEOUT_CYCLES=8, silent responder, plain read -> resp in cycle 10 with err=1, rdata=0. Guarded write to a silent responder -> only the guard strobe is issued, error resp in cycle 10.
- i_req held high with 3 reads to 0x00, 0x08, 0x0C -> strobes in cycles 1, 4, 7; resps in cycles 3, 6, 9; ready high in cycles 0, 3, 6, 9.
- Assert reset in cycle 2 of a read -> all outputs 0, ready=1 after release, no resp. A stray i_dout_32b_valid pulse in IDLE -> no o_resp_valid.

Source files
------------

// File: rtl/peri_initiator.sv
// Single-outstanding peripheral bus initiator with automatic guard-word unlock
// ahead of guarded writes and a response timeout.
module peri_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] GUARD_KEY      = 16'h1234
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_req_we,
  input  logic        i_req_guard,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_addr_32b,
  output logic        o_wren,
  output logic        o_rden,
  output logic [31:0] o_din_32b,
  input  logic [31:0] i_dout_32b,
  input  logic        i_dout_32b_valid
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, G_WAIT, WAIT} state_t;

  state_t        r_state,      w_state_nx;
  logic [CW-1:0] r_cnt,        w_cnt_nx;
  logic          r_we,         w_we_nx;
  logic [31:0]   r_tgt_addr,   w_tgt_addr_nx;
  logic [31:0]   r_tgt_wdata,  w_tgt_wdata_nx;
  logic          r_wren,       w_wren_nx;
  logic          r_rden,       w_rden_nx;
  logic [31:0]   r_addr,       w_addr_nx;
  logic [31:0]   r_din,        w_din_nx;
  logic          r_resp_valid, w_resp_valid_nx;
  logic          r_resp_err,   w_resp_err_nx;
  logic [31:0]   r_resp_rdata, w_resp_rdata_nx;

  logic w_strobe;
  logic w_timeout;
  logic w_unused_addr_lsb;

  assign w_strobe          = r_wren | r_rden;
  assign w_timeout         = (r_cnt == LAST_WAIT);
  assign w_unused_addr_lsb = ^i_req_addr[1:0];

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_we_nx         = r_we;
    w_tgt_addr_nx   = r_tgt_addr;
    w_tgt_wdata_nx  = r_tgt_wdata;
    w_wren_nx       = 1'b0;
    w_rden_nx       = 1'b0;
    w_addr_nx       = r_addr;
    w_din_nx        = r_din;
    w_resp_valid_nx = 1'b0;
    w_resp_err_nx   = 1'b0;
    w_resp_rdata_nx = '0;

    unique case (r_state)
      IDLE: begin
        if (i_req) begin
          w_cnt_nx = '0;
          w_we_nx  = i_req_we;
          if (i_req_we && i_req_guard) begin
            w_wren_nx      = 1'b1;
            w_addr_nx      = {i_req_addr[31:7], 5'd1, 2'b00};
            w_din_nx       = {16'h0000, GUARD_KEY};
            w_tgt_addr_nx  = {i_req_addr[31:2], 2'b00};
            w_tgt_wdata_nx = i_req_wdata;
            w_state_nx     = G_WAIT;
          end else begin
            w_wren_nx  = i_req_we;
            w_rden_nx  = !i_req_we;
            w_addr_nx  = {i_req_addr[31:2], 2'b00};
            w_din_nx   = i_req_we ? i_req_wdata : '0;
            w_state_nx = WAIT;
          end
        end
      end

      // The strobe cycle itself never counts as a wait cycle: the responder
      // answers at the earliest one cycle after the strobe.
      G_WAIT: begin
        if (!w_strobe) begin
          if (i_dout_32b_valid) begin
            w_wren_nx  = 1'b1;
            w_addr_nx  = r_tgt_addr;
            w_din_nx   = r_tgt_wdata;
            w_cnt_nx   = '0;
            w_state_nx = WAIT;
          end else if (w_timeout) begin
            w_resp_valid_nx = 1'b1;
            w_resp_err_nx   = 1'b1;
            w_state_nx      = IDLE;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
      end

      WAIT: begin
        if (!w_strobe) begin
          if (i_dout_32b_valid) begin
            w_resp_valid_nx = 1'b1;
            w_resp_rdata_nx = r_we ? '0 : i_dout_32b;
            w_state_nx      = IDLE;
          end else if (w_timeout) begin
            w_resp_valid_nx = 1'b1;
            w_resp_err_nx   = 1'b1;
            w_state_nx      = IDLE;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_tgt_addr   <= '0;
      r_tgt_wdata  <= '0;
      r_wren       <= 1'b0;
      r_rden       <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_we         <= w_we_nx;
      r_tgt_addr   <= w_tgt_addr_nx;
      r_tgt_wdata  <= w_tgt_wdata_nx;
      r_wren       <= w_wren_nx;
      r_rden       <= w_rden_nx;
      r_addr       <= w_addr_nx;
      r_din        <= w_din_nx;
      r_resp_valid <= w_resp_valid_nx;
      r_resp_err   <= w_resp_err_nx;
      r_resp_rdata <= w_resp_rdata_nx;
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_addr_32b   = r_addr;
  assign o_wren       = r_wren;
  assign o_rden       = r_rden;
  assign o_din_32b    = r_din;

endmodule
